// File: rtl/divisao_8x4_seq.sv
// divisao_8x4_seq: sequential restoring divider, one quotient bit per clock.
// Divides an unsigned DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor.
// Divide-by-zero returns all-ones quotient, zero remainder and flags div_zero.
//
// Optional feature macro: DIV_EARLY_EXIT_EN
//   When defined, a nonzero divisor larger than the dividend finishes in one
//   edge (quotient 0, remainder = dividend). Results are identical either way;
//   only the latency changes.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   start     in   request pulse, honoured in IDLE or DONE
//   dividend  in   numerator, captured on accepted start
//   divisor   in   denominator, captured on accepted start
//   busy      out  high while iterating (CALC)
//   done      out  one-cycle pulse, results valid (DONE)
//   quotient  out  result quotient, held until the next DONE
//   remainder out  result remainder, held until the next DONE
//   div_zero  out  divisor was zero for the last operation
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | ready, last result held on the outputs
// CALC  | iterating, one restoring step per edge
// DONE  | single cycle, results valid, ready for start

module divisao_8x4_seq #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_zero
);

   localparam int CNT_W = $clog2(DIVIDEND_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q;
   logic [DIVISOR_W:0]      p_q;
   logic [DIVIDEND_W-1:0]   q_q;
   logic [DIVISOR_W-1:0]    dvs_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    busy_q;
   logic                    done_q;
   logic [DIVIDEND_W-1:0]   quotient_q;
   logic [DIVISOR_W-1:0]    remainder_q;
   logic                    div_zero_q;

   // One restoring step: shift the next dividend bit into the partial
   // remainder, subtract the divisor when it fits.
   logic [DIVISOR_W:0]      p_shift;
   logic                    p_ge;
   logic [DIVISOR_W:0]      p_d;
   logic [DIVIDEND_W-1:0]   q_d;

   always_comb begin
      p_shift = {p_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
      p_ge    = (p_shift >= {1'b0, dvs_q});
      p_d     = p_ge ? (p_shift - {1'b0, dvs_q}) : p_shift;
      q_d     = {q_q[DIVIDEND_W-2:0], p_ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         p_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  dvs_q      <= divisor;
                  div_zero_q <= 1'b0;
                  if (divisor == '0) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     quotient_q  <= '1;
                     remainder_q <= '0;
                     div_zero_q  <= 1'b1;
                  end
`ifdef DIV_EARLY_EXIT_EN
                  else if (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor}) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     quotient_q  <= '0;
                     remainder_q <= dividend[DIVISOR_W-1:0];
                  end
`endif
                  else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                     p_q     <= '0;
                     q_q     <= dividend;
                     cnt_q   <= CNT_W'(DIVIDEND_W);
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               p_q   <= p_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  quotient_q  <= q_d;
                  // Final partial remainder is always below the divisor,
                  // so its top bit is zero.
                  remainder_q <= p_d[DIVISOR_W-1:0];
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divisao_8x4_seq.sv
module tb_divisao_8x4_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_zero;

`ifdef DIV_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;

   divisao_8x4_seq #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
      int         lat;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // lat counts edges from acceptance (inclusive) until done is seen.
   task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int lat);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done) lat = 99;
   endtask

   initial begin
      int lat;
      int bad_inv;
      int bad_exact;
      int bad_lat;
      int dcount;

      vecs[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9};
      vecs[1]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 9};
      vecs[2]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 9};
      vecs[3]  = '{8'd5,   4'd0,  8'hFF,  4'd0,  1'b1, 1};
      vecs[4]  = '{8'd9,   4'd3,  8'd3,   4'd0,  1'b0, 9};
      vecs[5]  = '{8'd3,   4'd9,  8'd0,   4'd3,  1'b0, EARLY ? 1 : 9};
      vecs[6]  = '{8'd100, 4'd9,  8'd11,  4'd1,  1'b0, 9};
      vecs[7]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0, EARLY ? 1 : 9};
      vecs[8]  = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0, 9};
      vecs[9]  = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0, EARLY ? 1 : 9};
      vecs[10] = '{8'd128, 4'd3,  8'd42,  4'd2,  1'b0, 9};
      vecs[11] = '{8'd1,   4'd1,  8'd1,   4'd0,  1'b0, 9};

      rst = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_div_zero", div_zero, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table vectors, with idle cycles between ops.
      for (int i = 0; i < 12; i++) begin
         repeat (2) @(posedge clk);
         do_op(vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
         chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
         chk($sformatf("v%0d_div_zero", i), div_zero, vecs[i].dz);
         chk($sformatf("v%0d_busy_in_done", i), busy, 0);
      end

      // Back-to-back: second start issued in the DONE cycle of the first.
      repeat (2) @(posedge clk);
      do_op(8'd255, 4'd15, lat);
      chk("b2b_first_quotient", quotient, 17);
      chk("b2b_first_done", done, 1);
      @(negedge clk);
      dividend = 8'd255;
      divisor  = 4'd1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_no_gap_busy", busy, 1);
      chk("b2b_no_gap_done", done, 0);
      chk("b2b_hold_quotient", quotient, 17);
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("b2b_second_latency", lat, 9);
      chk("b2b_second_quotient", quotient, 255);
      chk("b2b_second_remainder", remainder, 0);

      // Start pulse mid-CALC is ignored; input changes during CALC have no effect.
      repeat (2) @(posedge clk);
      @(negedge clk);
      dividend = 8'd200;
      divisor  = 4'd7;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 1;
      repeat (3) begin
         @(posedge clk);
         #1;
         lat++;
      end
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 4'd9;
      start    = 1'b1;
      @(posedge clk);
      #1;
      lat++;
      start    = 1'b0;
      dividend = 8'd50;
      divisor  = 4'd3;
      chk("midcalc_busy", busy, 1);
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("midcalc_latency", lat, 9);
      chk("midcalc_quotient", quotient, 28);
      chk("midcalc_remainder", remainder, 4);
      @(posedge clk);
      #1;
      chk("midcalc_after_done", done, 0);
      chk("midcalc_after_busy", busy, 0);
      chk("idle_hold_quotient", quotient, 28);

      // Reset at CALC step 4 aborts with no done pulse.
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 4'd9;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("calc_hold_quotient", quotient, 28);
      chk("calc_hold_remainder", remainder, 4);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      @(negedge clk);
      rst = 1'b0;
      dcount = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) dcount++;
      end
      chk("abort_no_done_pulse", dcount, 0);

      // Exhaustive nonzero-divisor sweep, back to back.
      bad_inv = 0;
      bad_exact = 0;
      bad_lat = 0;
      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            do_op(8'(a), 4'(b), lat);
            if ((int'(quotient) * b + int'(remainder)) != a || int'(remainder) >= b)
               bad_inv++;
            if (int'(quotient) != a / b || int'(remainder) != a % b || div_zero)
               bad_exact++;
            if (lat != ((EARLY && a < b) ? 1 : 9))
               bad_lat++;
         end
      end
      chk("exhaustive_invariant_bad", bad_inv, 0);
      chk("exhaustive_exact_bad", bad_exact, 0);
      chk("exhaustive_latency_bad", bad_lat, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
